sync_period_meter: RTL

//  Consumes a sync level (HSYNC/VSYNC) already brought into the capture clock domain by the CDC stage.

---
 rtl/sync_period_meter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sync_period_meter.sv
// rtl/sync_period_meter.sv - sync glitch filter with start/end pulses, period/width meter and lock detector
// Operates entirely in i_clk; i_sync must already be synchronised.
module sync_period_meter #(
  parameter int CNT_W      = 16,
  parameter int GLITCH_LEN = 2,
  parameter int LOCK_CNT   = 4,
  parameter int TOL        = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sync,
  input  logic             i_active_low,
  input  logic             i_clr,
  output logic             o_start,
  output logic             o_end,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_width,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int GW = $clog2(GLITCH_LEN + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CMAX    = '1;
  localparam logic [CNT_W-1:0] CMAX_M1 = CMAX - 1'b1;
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, LOCKED} state_t;

  state_t           state;
  logic             act_r;
  logic             filt;
  logic [GW-1:0]    gcnt;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    match_cnt;

  logic             disagree;
  logic             flip;
  logic             start_ev;
  logic             end_ev;
  logic [CNT_W-1:0] cnt_inc;
  logic [MW-1:0]    match_cnt_inc;
  logic [CNT_W:0]   cur_ext;
  logic [CNT_W:0]   prev_ext;
  logic [CNT_W:0]   diff;
  logic             is_match;

  // The filtered level flips only on the sample after GLITCH_LEN disagreeing ones.
  assign disagree = (act_r != filt);
  assign flip     = disagree && (gcnt == GW'(GLITCH_LEN));
  assign start_ev = flip && !filt;
  assign end_ev   = flip && filt;

  assign cnt_inc       = (cnt == CMAX) ? CMAX : cnt + 1'b1;
  assign match_cnt_inc = match_cnt + 1'b1;
  assign cur_ext       = {1'b0, cnt_inc};
  assign prev_ext      = {1'b0, o_period};
  assign diff          = (cur_ext >= prev_ext) ? (cur_ext - prev_ext) : (prev_ext - cur_ext);
  assign is_match      = (diff <= TOL_V);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_r   <= 1'b0;
      filt    <= 1'b0;
      gcnt    <= '0;
      o_start <= 1'b0;
      o_end   <= 1'b0;
    end else begin
      act_r   <= i_sync ^ i_active_low;
      o_start <= start_ev;
      o_end   <= end_ev;
      if (flip) begin
        filt <= ~filt;
        gcnt <= '0;
      end else if (disagree) begin
        gcnt <= gcnt + 1'b1;
      end else begin
        gcnt <= '0;
      end
    end
  end

  // Measurement FSM; the filter above keeps running through i_clr.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      match_cnt <= '0;
      o_period  <= '0;
      o_width   <= '0;
      o_valid   <= 1'b0;
      o_locked  <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      if (i_clr) begin
        state     <= IDLE;
        cnt       <= '0;
        match_cnt <= '0;
        o_locked  <= 1'b0;
      end else begin
        cnt <= start_ev ? '0 : cnt_inc;
        if (end_ev && (state != IDLE)) begin
          o_width <= cnt_inc;
        end
        if (start_ev) begin
          case (state)
            IDLE: state <= ARMED;
            ARMED: begin
              o_period  <= cnt_inc;
              o_valid   <= 1'b1;
              match_cnt <= '0;
              state     <= MEASURE;
            end
            MEASURE: begin
              o_period <= cnt_inc;
              o_valid  <= 1'b1;
              if (is_match) begin
                match_cnt <= match_cnt_inc;
                if (match_cnt_inc == MW'(LOCK_CNT)) begin
                  state    <= LOCKED;
                  o_locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end
            LOCKED: begin
              o_period <= cnt_inc;
              o_valid  <= 1'b1;
              if (!is_match) begin
                state     <= MEASURE;
                match_cnt <= '0;
                o_locked  <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end else if ((state != IDLE) && (cnt == CMAX_M1)) begin
          // Counter saturates on this edge: the line is gone.
          o_timeout <= 1'b1;
          state     <= IDLE;
          match_cnt <= '0;
          o_locked  <= 1'b0;
        end
      end
    end
  end

endmodule
